varredura_display: RTL and testbench
====================================

VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 SHALL have parameter DIV_REFRESH, default 50000, meaning clock cycles each digit stays lit per scan; legal range 1..2^20.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port carregar, input, 1, load strobe for a new BCD pair.
REQ-005 SHALL have port unidades, input, 4, BCD units digit from the binary-to-BCD stage.
REQ-006 SHALL have port dezenas, input, 4, BCD tens digit from the binary-to-BCD stage.
REQ-007 SHALL have port seg, output, 7, {g,f,e,d,c,b,a}, active-low, where 0 lights a segment.
REQ-008 SHALL have port anodo, output, 2, {tens,units} digit enables, active-low.
REQ-009 SHALL have port pronto, output, 1, one-cycle pulse marking the end of each full scan frame.

Function
REQ-010 SHALL capture unidades/dezenas into internal latches on every clock edge where carregar=1 and reset=0; otherwise latches SHALL hold.
REQ-011 SHALL use a Moore FSM with states S_UNI, S_GAP0, S_DEZ, S_GAP1; outputs SHALL be decoded combinationally from the registered state, counter and latches only.
REQ-012 S_UNI and S_DEZ SHALL each last exactly DIV_REFRESH cycles, counted by a refresh counter from 0 to DIV_REFRESH-1, which SHALL clear on every state change.
REQ-013 S_GAP0 and S_GAP1 SHALL each last exactly 1 cycle, giving an anti-ghosting blank; transitions SHALL be S_UNI->S_GAP0->S_DEZ->S_GAP1->S_UNI; frame length SHALL be 2*DIV_REFRESH+2 cycles.
REQ-014 In S_UNI: anodo=2'b10 and seg=encode(units latch); in S_DEZ: anodo=2'b01 and seg=encode(tens latch); in gap states: anodo=2'b11 and seg=7'b1111111.
REQ-015 encode SHALL map 0..9 to standard active-low patterns (0=7'b1000000, 1=7'b1111001, 8=7'b0000000); codes 10..15 SHALL map to dash 7'b0111111.
REQ-016 pronto SHALL be 1 exactly while in S_GAP1 and 0 otherwise.
REQ-017 Load latency: a value captured at edge N SHALL appear on seg from cycle N+1 whenever its digit is active; a load mid-digit SHALL change seg immediately without restarting the counter or FSM.
REQ-018 With DIV_REFRESH=1, each digit state SHALL last exactly 1 cycle, giving a frame of 4 cycles.

Reset
REQ-019 reset=1 at an edge SHALL force state S_UNI, counter 0 and both latches 0, and SHALL override a simultaneous carregar.
REQ-020 During and immediately after reset, outputs SHALL be anodo=2'b10, seg=7'b1000000 and pronto=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no pronto pulse; the next frame SHALL start from S_UNI.

Configuration
REQ-022 Macro APAGAR_ZERO_EN defined: in S_DEZ with a tens latch of 0, anodo SHALL be 2'b11 and seg 7'b1111111 for the whole slot, with timing unchanged.
REQ-023 APAGAR_ZERO_EN undefined: the tens slot SHALL always display the latched tens digit, including 0.

Structure
REQ-024 Package varredura_pkg SHALL hold the state enum, the 16-entry segment table, SEG_APAGADO (7'b1111111) and SEG_TRACO (7'b0111111).
REQ-025 BCD-to-segment decode SHALL be a combinational sub-module decod_7seg, instantiated once and fed by a mux of the two latches.

Verification (DIV_REFRESH=4)
REQ-026 Reset then idle 10 cycles -> anodo 10,10,10,10,11,01,01,01,01,11 repeating; pronto high only on the 10th cycle; seg shows 0 in both digit slots.
REQ-027 carregar=1 with unidades=7, dezenas=2 -> units slot seg=7'b1111000, tens slot seg=7'b0100100 from the next cycle.
REQ-028 Load unidades=4'hB -> units slot seg=7'b0111111 (dash).
REQ-029 Load dezenas=0, unidades=5 -> tens slot anodo=11 with APAGAR_ZERO_EN defined; anodo=01 and seg=7'b1000000 without it.
REQ-030 Assert reset together with carregar (value 31) mid-S_DEZ -> next cycle anodo=10, seg=7'b1000000, latches 0, and no pronto in the aborted frame.
REQ-031 Load 1 then 3 in consecutive cycles during S_UNI -> seg changes 1->3 without any change in frame timing.

Source files
------------

// File: rtl/varredura_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
package varredura_pkg;

    typedef enum logic [1:0] {
        S_UNI  = 2'd0,
        S_GAP0 = 2'd1,
        S_DEZ  = 2'd2,
        S_GAP1 = 2'd3
    } estado_t;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_TRACO   = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABELA = {
        SEG_TRACO, SEG_TRACO, SEG_TRACO,
        SEG_TRACO, SEG_TRACO, SEG_TRACO,
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/decod_7seg.sv
// BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module decod_7seg
    import varredura_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = SEG_TABELA[bcd];

endmodule

// File: rtl/varredura_display.sv
// Two-digit multiplexed display scanner with blanking gaps between digits.
// Optional macro APAGAR_ZERO_EN blanks the tens digit when it is zero.
module varredura_display
    import varredura_pkg::*;
#(
    parameter int unsigned DIV_REFRESH = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carregar,
    input  logic [3:0] unidades,
    input  logic [3:0] dezenas,
    output logic [6:0] seg,
    output logic [1:0] anodo,
    output logic       pronto
);

    localparam int unsigned CW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_REFRESH - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    uni_q, dez_q;
    logic [3:0]    digito;
    logic [6:0]    seg_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= S_UNI;
            cnt_q    <= '0;
            uni_q    <= '0;
            dez_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            if (carregar) begin
                uni_q <= unidades;
                dez_q <= dezenas;
            end
        end
    end

    // Counter restarts whenever the state changes; gaps always leave after one cycle.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            S_UNI:  if (cnt_q == CNT_MAX) estado_d = S_GAP0;
            S_GAP0: estado_d = S_DEZ;
            S_DEZ:  if (cnt_q == CNT_MAX) estado_d = S_GAP1;
            S_GAP1: estado_d = S_UNI;
            default: estado_d = S_UNI;
        endcase
        cnt_d = (estado_d != estado_q) ? '0 : cnt_q + 1'b1;
    end

    assign digito = (estado_q == S_DEZ) ? dez_q : uni_q;

    decod_7seg u_decod (
        .bcd (digito),
        .seg (seg_dec)
    );

    always_comb begin
        anodo  = 2'b11;
        seg    = SEG_APAGADO;
        pronto = 1'b0;
        unique case (estado_q)
            S_UNI: begin
                anodo = 2'b10;
                seg   = seg_dec;
            end
            S_DEZ: begin
`ifdef APAGAR_ZERO_EN
                if (dez_q != 4'd0) begin
                    anodo = 2'b01;
                    seg   = seg_dec;
                end
`else
                anodo = 2'b01;
                seg   = seg_dec;
`endif
            end
            S_GAP1: pronto = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_varredura_display.sv
// Self-checking bench: frame-position model for DIV_REFRESH=4 and =1 plus literal spot checks.
module tb_varredura_display;

    localparam int D0 = 4;
    localparam int F0 = 2 * D0 + 2;
    localparam int D1 = 1;
    localparam int F1 = 2 * D1 + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       carregar = 1'b0;
    logic [3:0] unidades = '0;
    logic [3:0] dezenas = '0;
    logic [6:0] seg0, seg1;
    logic [1:0] anodo0, anodo1;
    logic       pronto0, pronto1;

    int checks = 0;
    int errors = 0;

    // Model state: position inside the frame and the latched digits.
    int         p0 = 0, p1 = 0;
    logic [3:0] mu = '0, md = '0;
    bit         started = 0;

    always #5 clk = ~clk;

    varredura_display #(.DIV_REFRESH(D0)) u0 (
        .clk(clk), .reset(reset), .carregar(carregar),
        .unidades(unidades), .dezenas(dezenas),
        .seg(seg0), .anodo(anodo0), .pronto(pronto0)
    );

    varredura_display #(.DIV_REFRESH(D1)) u1 (
        .clk(clk), .reset(reset), .carregar(carregar),
        .unidades(unidades), .dezenas(dezenas),
        .seg(seg1), .anodo(anodo1), .pronto(pronto1)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic void expect_out(input int d, input int p, input logic [3:0] u,
                                       input logic [3:0] t, output logic [1:0] an,
                                       output logic [6:0] sg, output logic pr);
        an = 2'b11;
        sg = 7'b1111111;
        pr = 1'b0;
        if (p < d) begin
            an = 2'b10;
            sg = seg_of(u);
        end else if (p > d && p <= 2 * d) begin
            an = 2'b01;
            sg = seg_of(t);
`ifdef APAGAR_ZERO_EN
            if (t == 4'd0) begin
                an = 2'b11;
                sg = 7'b1111111;
            end
`endif
        end else if (p == 2 * d + 1) begin
            pr = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            p0 = 0;
            p1 = 0;
            mu = '0;
            md = '0;
            started = 1;
        end else begin
            p0 = (p0 + 1) % F0;
            p1 = (p1 + 1) % F1;
            if (carregar) begin
                mu = unidades;
                md = dezenas;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] an;
        logic [6:0] sg;
        logic       pr;
        if (started) begin
            expect_out(D0, p0, mu, md, an, sg, pr);
            chk("d4_anodo", 32'(anodo0), 32'(an));
            chk("d4_seg", 32'(seg0), 32'(sg));
            chk("d4_pronto", 32'(pronto0), 32'(pr));
            expect_out(D1, p1, mu, md, an, sg, pr);
            chk("d1_anodo", 32'(anodo1), 32'(an));
            chk("d1_seg", 32'(seg1), 32'(sg));
            chk("d1_pronto", 32'(pronto1), 32'(pr));
        end
    end

    task automatic wait_pos(input int target);
        int n = 0;
        while (p0 != target && n < 3 * F0) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pos_timeout", 32'(p0), 32'(target));
    endtask

    initial begin
        logic [1:0] an_seq [10];
        logic [1:0] an_exp [10];
        logic       pr_seq [10];
        an_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};

        // Reset and idle: anodo pattern and single pronto per frame.
        repeat (2) @(negedge clk);
        chk("reset_anodo", 32'(anodo0), 32'(2'b10));
        chk("reset_seg", 32'(seg0), 32'(7'b1000000));
        chk("reset_pronto", 32'(pronto0), 32'(1'b0));
        reset = 1'b0;
        an_seq[0] = anodo0;
        pr_seq[0] = pronto0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            an_seq[i] = anodo0;
            pr_seq[i] = pronto0;
        end
        for (int i = 0; i < 10; i++) begin
            chk("idle_anodo_seq", 32'(an_seq[i]), 32'(an_exp[i]));
            chk("idle_pronto_seq", 32'(pr_seq[i]), (i == 9) ? 32'd1 : 32'd0);
        end

        // Load 7/2 at frame start.
        carregar = 1'b1; unidades = 4'd7; dezenas = 4'd2;
        @(negedge clk);
        carregar = 1'b0;
        chk("load72_uni", 32'(seg0), 32'(7'b1111000));
        wait_pos(D0 + 2);
        chk("load72_dez_anodo", 32'(anodo0), 32'(2'b01));
        chk("load72_dez", 32'(seg0), 32'(7'b0100100));

        // Invalid units code shows a dash.
        carregar = 1'b1; unidades = 4'hB; dezenas = 4'd2;
        @(negedge clk);
        carregar = 1'b0;
        wait_pos(1);
        chk("dash_uni", 32'(seg0), 32'(7'b0111111));

        // Zero tens digit.
        carregar = 1'b1; unidades = 4'd5; dezenas = 4'd0;
        @(negedge clk);
        carregar = 1'b0;
        wait_pos(D0 + 1);
`ifdef APAGAR_ZERO_EN
        chk("zero_dez_anodo", 32'(anodo0), 32'(2'b11));
        chk("zero_dez_seg", 32'(seg0), 32'(7'b1111111));
`else
        chk("zero_dez_anodo", 32'(anodo0), 32'(2'b01));
        chk("zero_dez_seg", 32'(seg0), 32'(7'b1000000));
`endif

        // Reset with simultaneous load mid tens slot.
        wait_pos(D0 + 2);
        reset = 1'b1; carregar = 1'b1; unidades = 4'd1; dezenas = 4'd3;
        @(negedge clk);
        reset = 1'b0; carregar = 1'b0;
        chk("rst_mid_anodo", 32'(anodo0), 32'(2'b10));
        chk("rst_mid_seg", 32'(seg0), 32'(7'b1000000));
        chk("rst_mid_pronto", 32'(pronto0), 32'(1'b0));

        // Back-to-back loads inside the units slot.
        carregar = 1'b1; unidades = 4'd1; dezenas = 4'd0;
        @(negedge clk);
        chk("b2b_first", 32'(seg0), 32'(7'b1111001));
        unidades = 4'd3;
        @(negedge clk);
        carregar = 1'b0;
        chk("b2b_second", 32'(seg0), 32'(7'b0110000));
        chk("b2b_anodo", 32'(anodo0), 32'(2'b10));
        @(negedge clk);
        chk("b2b_still_uni", 32'(anodo0), 32'(2'b10));
        @(negedge clk);
        chk("b2b_gap", 32'(anodo0), 32'(2'b11));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            carregar = ($urandom_range(0, 3) == 0);
            unidades = 4'($urandom_range(0, 15));
            dezenas  = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        reset = 1'b0;
        carregar = 1'b0;
        repeat (F0) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
